// File: rtl/mouse_cursor_tracker_pkg.sv
// Shared definitions for the cursor tracker: FSM states, screen bounds, position width.
// Also provides the true two's-complement absolute value used on the 9-bit mouse deltas.
package fishing_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    APPLY_X,
    APPLY_Y,
    DONE
  } state_t;

  localparam int POS_W      = 14;
  localparam int DEF_H_MAX  = 6400;
  localparam int DEF_V_MAX  = 4800;
  localparam int DEF_H_INIT = 3200;
  localparam int DEF_V_INIT = 2400;

  // -256 maps to 256, so the result needs one bit more than the delta
  function automatic logic [9:0] abs9(input logic [8:0] d);
    logic [9:0] e;
    e = {d[8], d};
    return d[8] ? (~e + 10'd1) : e;
  endfunction

endpackage

// File: rtl/mouse_cursor_tracker_if.sv
// Packet-in / cursor-out bundle between the PS/2 receiver side and the tracker.
interface mouse_cursor_tracker_if;
  logic [8:0]                   xm;
  logic [8:0]                   ym;
  logic [2:0]                   btnm;
  logic                         m_done_tick;
  logic                         freeze;
  logic [fishing_pkg::POS_W-1:0] h_pos;
  logic [fishing_pkg::POS_W-1:0] v_pos;
  logic                         pos_upd;
  logic                         click_l;
  logic [2:0]                   btn_held;
  logic [7:0]                   drop_cnt;

  modport master (
    output xm, ym, btnm, m_done_tick, freeze,
    input  h_pos, v_pos, pos_upd, click_l, btn_held, drop_cnt
  );

  modport slave (
    input  xm, ym, btnm, m_done_tick, freeze,
    output h_pos, v_pos, pos_upd, click_l, btn_held, drop_cnt
  );
endinterface

// File: rtl/mouse_cursor_tracker_sat_step.sv
// One-axis saturating step: moves pos by mag toward limit (inc) or toward 0, clamped.
module sat_step
  import fishing_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  logic [POS_W-1:0] mag,
  input  logic [POS_W-1:0] limit,
  input  logic             inc,
  output logic [POS_W-1:0] next
);

  logic [POS_W:0] sum;

  assign sum = {1'b0, pos} + {1'b0, mag};

  always_comb begin
    if (inc) begin
      next = (sum > {1'b0, limit}) ? limit : sum[POS_W-1:0];
    end else begin
      next = (pos < mag) ? '0 : pos - mag;
    end
  end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Sequenced cursor tracker: one mouse packet -> saturating h/v position, click pulse, update strobe.
// Optional MOUSE_ACCEL_EN doubles the gain on an axis whose |delta| exceeds ACCEL_THRESH.
module mouse_cursor_tracker
  import fishing_pkg::*;
#(
  parameter int H_MAX        = DEF_H_MAX,
  parameter int V_MAX        = DEF_V_MAX,
  parameter int H_INIT       = DEF_H_INIT,
  parameter int V_INIT       = DEF_V_INIT,
  parameter int GAIN_SHIFT   = 1,
  parameter int ACCEL_THRESH = 32
) (
  input logic                   clk,
  input logic                   rst,
  mouse_cursor_tracker_if.slave bus
);

`ifdef MOUSE_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  state_t state, state_nx;

  logic [8:0]       xm_reg, ym_reg;
  logic [2:0]       btnm_reg;
  logic [POS_W-1:0] mag_x, mag_y;
  logic             neg_x, neg_y, click_rise;
  logic [POS_W-1:0] h_pos, v_pos, h_next, v_next;
  logic             pos_upd, click_l;
  logic [2:0]       btn_held;
  logic [7:0]       drop_cnt;

  logic [9:0]       abs_x, abs_y;
  logic [POS_W-1:0] scaled_x, scaled_y;

  assign abs_x = abs9(xm_reg);
  assign abs_y = abs9(ym_reg);

  // Per-axis acceleration decision; the threshold compare is inert unless the macro is set
  assign scaled_x = (ACCEL_ON && (abs_x > 10'(ACCEL_THRESH))) ?
                    (POS_W'(abs_x) << (GAIN_SHIFT + 1)) : (POS_W'(abs_x) << GAIN_SHIFT);
  assign scaled_y = (ACCEL_ON && (abs_y > 10'(ACCEL_THRESH))) ?
                    (POS_W'(abs_y) << (GAIN_SHIFT + 1)) : (POS_W'(abs_y) << GAIN_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.m_done_tick) state_nx = LATCH;
      LATCH:   state_nx = APPLY_X;
      APPLY_X: state_nx = APPLY_Y;
      APPLY_Y: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xm_reg     <= '0;
      ym_reg     <= '0;
      btnm_reg   <= '0;
      mag_x      <= '0;
      mag_y      <= '0;
      neg_x      <= 1'b0;
      neg_y      <= 1'b0;
      click_rise <= 1'b0;
      h_pos      <= POS_W'(H_INIT);
      v_pos      <= POS_W'(V_INIT);
      pos_upd    <= 1'b0;
      click_l    <= 1'b0;
      btn_held   <= '0;
      drop_cnt   <= '0;
    end else begin
      pos_upd <= 1'b0;
      click_l <= 1'b0;
      if (bus.m_done_tick && (state != IDLE) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (bus.m_done_tick) begin
            xm_reg   <= bus.xm;
            ym_reg   <= bus.ym;
            btnm_reg <= bus.btnm;
          end
        end
        LATCH: begin
          mag_x      <= scaled_x;
          mag_y      <= scaled_y;
          neg_x      <= xm_reg[8];
          neg_y      <= ym_reg[8];
          click_rise <= btnm_reg[0] & ~btn_held[0];
        end
        APPLY_X: begin
          if (!bus.freeze) h_pos <= h_next;
        end
        APPLY_Y: begin
          if (!bus.freeze) v_pos <= v_next;
          // Registered strobes land in the DONE cycle
          pos_upd <= 1'b1;
          click_l <= click_rise;
        end
        DONE:    btn_held <= btnm_reg;
        default: ;
      endcase
    end
  end

  // Screen Y grows downward, so a positive ym moves toward 0
  sat_step u_step_h (.pos(h_pos), .mag(mag_x), .limit(POS_W'(H_MAX)), .inc(~neg_x), .next(h_next));
  sat_step u_step_v (.pos(v_pos), .mag(mag_y), .limit(POS_W'(V_MAX)), .inc(neg_y),  .next(v_next));

  assign bus.h_pos    = h_pos;
  assign bus.v_pos    = v_pos;
  assign bus.pos_upd  = pos_upd;
  assign bus.click_l  = click_l;
  assign bus.btn_held = btn_held;
  assign bus.drop_cnt = drop_cnt;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Self-checking bench: directed vector table, corner sequences and a random run against an arithmetic model.
module tb_mouse_cursor_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int h_m, v_m, drop_m;
  logic [2:0] bh_m;

  mouse_cursor_tracker_if bus ();

  mouse_cursor_tracker dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] b;
    logic       frz;
    int         eh;
    int         ev;
    logic       ec;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Applies one packet, checks the 4-cycle strobe latency and the resulting state
  task automatic do_packet(input int x, input int y, input logic [2:0] b, input logic frz,
                           input int eh, input int ev, input logic ec);
    int early;
    early = 0;
    @(negedge clk);
    bus.xm = 9'(x);
    bus.ym = 9'(y);
    bus.btnm = b;
    bus.freeze = frz;
    bus.m_done_tick = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.m_done_tick = 1'b0;
      if (bus.pos_upd) early++;
    end
    check("pos_upd_early", early, 0);
    @(negedge clk);
    check("pos_upd", int'(bus.pos_upd), 1);
    check("h_pos", int'(bus.h_pos), eh);
    check("v_pos", int'(bus.v_pos), ev);
    check("click_l", int'(bus.click_l), int'(ec));
    @(negedge clk);
    bus.freeze = 1'b0;
    check("pos_upd_once", int'(bus.pos_upd), 0);
    check("btn_held", int'(bus.btn_held), int'(b));
    check("drop_cnt", int'(bus.drop_cnt), drop_m);
    h_m = eh;
    v_m = ev;
    bh_m = b;
  endtask

  function automatic int model_mag(input int d);
    int a;
    a = (d < 0) ? -d : d;
`ifdef MOUSE_ACCEL_EN
    if (a > 32) return a * 4;
`endif
    return a * 2;
  endfunction

  initial begin
    int x, y, mx, my, eh, ev;
    logic [2:0] b;
    logic frz, ec;

    bus.xm = '0;
    bus.ym = '0;
    bus.btnm = '0;
    bus.freeze = 1'b0;
    bus.m_done_tick = 1'b0;
    h_m = 3200; v_m = 2400; bh_m = '0; drop_m = 0;

    tbl[0]  = '{10,   5,    3'b000, 1'b0, 3220, 2390, 1'b0};
    tbl[1]  = '{255,  -5,   3'b000, 1'b0, 3730, 2400, 1'b0};
    tbl[2]  = '{255,  0,    3'b001, 1'b0, 4240, 2400, 1'b1};
    tbl[3]  = '{255,  0,    3'b001, 1'b0, 4750, 2400, 1'b0};
    tbl[4]  = '{255,  0,    3'b000, 1'b0, 5260, 2400, 1'b0};
    tbl[5]  = '{255,  0,    3'b001, 1'b0, 5770, 2400, 1'b1};
    tbl[6]  = '{255,  0,    3'b110, 1'b0, 6280, 2400, 1'b0};
    tbl[7]  = '{55,   0,    3'b000, 1'b0, 6390, 2400, 1'b0};
    tbl[8]  = '{20,   0,    3'b000, 1'b0, 6400, 2400, 1'b0};
    tbl[9]  = '{0,    255,  3'b000, 1'b0, 6400, 1890, 1'b0};
    tbl[10] = '{0,    255,  3'b000, 1'b0, 6400, 1380, 1'b0};
    tbl[11] = '{0,    255,  3'b000, 1'b0, 6400, 870,  1'b0};
    tbl[12] = '{0,    255,  3'b000, 1'b0, 6400, 360,  1'b0};
    tbl[13] = '{0,    255,  3'b000, 1'b0, 6400, 0,    1'b0};
    tbl[14] = '{-256, 255,  3'b000, 1'b0, 5888, 0,    1'b0};
    tbl[15] = '{50,   -20,  3'b001, 1'b1, 5888, 0,    1'b1};
    tbl[16] = '{-256, -256, 3'b000, 1'b0, 5376, 512,  1'b0};
    tbl[17] = '{0,    0,    3'b000, 1'b0, 5376, 512,  1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_h_pos", int'(bus.h_pos), 3200);
    check("rst_v_pos", int'(bus.v_pos), 2400);
    check("rst_pos_upd", int'(bus.pos_upd), 0);
    check("rst_click_l", int'(bus.click_l), 0);
    check("rst_btn_held", int'(bus.btn_held), 0);
    check("rst_drop_cnt", int'(bus.drop_cnt), 0);

`ifndef MOUSE_ACCEL_EN
    for (int i = 0; i < 18; i++) begin
      do_packet(tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].frz, tbl[i].eh, tbl[i].ev, tbl[i].ec);
    end
    do_packet(40, 0, 3'b000, 1'b0, h_m + 80, v_m, 1'b0);
`else
    do_packet(40, 0, 3'b000, 1'b0, 3360, 2400, 1'b0);
    do_packet(20, 0, 3'b000, 1'b0, 3400, 2400, 1'b0);
    do_packet(-33, 33, 3'b000, 1'b0, 3268, 2268, 1'b0);
`endif

    // Second tick two cycles after the first is dropped
    @(negedge clk);
    bus.xm = 9'(10); bus.ym = '0; bus.btnm = '0; bus.m_done_tick = 1'b1;
    @(negedge clk);
    bus.m_done_tick = 1'b0;
    @(negedge clk);
    bus.xm = 9'(100); bus.btnm = 3'b001; bus.m_done_tick = 1'b1;
    @(negedge clk);
    bus.m_done_tick = 1'b0;
    @(negedge clk);
    check("drop_pos_upd", int'(bus.pos_upd), 1);
    check("drop_h_pos", int'(bus.h_pos), (h_m + 20 > 6400) ? 6400 : h_m + 20);
    check("drop_click_l", int'(bus.click_l), 0);
    @(negedge clk);
    check("drop_cnt_one", int'(bus.drop_cnt), 1);
    check("drop_btn_held", int'(bus.btn_held), 0);
    drop_m = 1;
    h_m = (h_m + 20 > 6400) ? 6400 : h_m + 20;

    // Reset in the middle of a sequence aborts it
    @(negedge clk);
    bus.xm = 9'(100); bus.btnm = 3'b001; bus.m_done_tick = 1'b1;
    @(negedge clk);
    bus.m_done_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_h_pos", int'(bus.h_pos), 3200);
    check("arst_drop_cnt", int'(bus.drop_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus.pos_upd) seen++;
      end
      check("abort_no_pos_upd", seen, 0);
    end
    check("abort_h_pos", int'(bus.h_pos), 3200);
    check("abort_v_pos", int'(bus.v_pos), 2400);
    check("abort_btn_held", int'(bus.btn_held), 0);
    h_m = 3200; v_m = 2400; bh_m = '0; drop_m = 0;

    for (int n = 0; n < 40; n++) begin
      x = int'($urandom_range(511)) - 256;
      y = int'($urandom_range(511)) - 256;
      b = 3'($urandom_range(7));
      frz = ($urandom_range(3) == 0);
      mx = model_mag(x);
      my = model_mag(y);
      eh = h_m; ev = v_m;
      if (!frz) begin
        if (x >= 0) eh = (h_m + mx > 6400) ? 6400 : h_m + mx;
        else        eh = (h_m < mx) ? 0 : h_m - mx;
        if (y >= 0) ev = (v_m < my) ? 0 : v_m - my;
        else        ev = (v_m + my > 4800) ? 4800 : v_m + my;
      end
      ec = b[0] && !bh_m[0];
      do_packet(x, y, b, frz, eh, ev, ec);
    end

    // Continuous ticks: four of every five land while busy, saturating the counter
    @(negedge clk);
    bus.xm = '0; bus.ym = '0; bus.btnm = '0; bus.m_done_tick = 1'b1;
    repeat (400) @(negedge clk);
    bus.m_done_tick = 1'b0;
    repeat (6) @(negedge clk);
    check("drop_cnt_sat", int'(bus.drop_cnt), 255);
    check("sat_h_pos", int'(bus.h_pos), h_m);
    check("sat_v_pos", int'(bus.v_pos), v_m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
